rename_unit: RTL
================

Name: rename_unit

Overview:
Parametrised, synthesisable register-rename stage that replaces the software rename model.
- Renames up to PLANE_WIDTH instructions per cycle with intra-group dependency bypass.
- Allocates physical destinations from a bit-vector free list.
- Keeps a speculative and a committed map table; flush restores both map and free list to committed state.
- Sits between decode and dispatch.

Parameters:
PLANE_WIDTH, 2, rename slots per cycle (W)
LREG_BITS, 5, logical register index width (L); NUM_LREGS=2^L
PREG_BITS, 6, physical register index width (P); NUM_PREGS=2^P, must exceed NUM_LREGS+W

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  W  per-slot rename request
req_ldst_en  in  W  slot writes a destination
lrs1  in  W*L  slot k at [k*L+:L]
lrs2  in  W*L  logical source 2
ldst  in  W*L  logical destination
req_ready  out  1  group accepted when high
prs1  out  W*P  physical source 1, slot k at [k*P+:P]
prs2  out  W*P  physical source 2
pdst  out  W*P  allocated physical destination
old_pdst  out  W*P  previous mapping of ldst
commit_valid  in  W  per-slot commit
commit_ldst_en  in  W  committed slot has a destination
commit_ldst  in  W*L  committed logical destination
commit_pdst  in  W*P  committed physical destination
commit_old_pdst  in  W*P  physical register to free
flush  in  1  restore committed state
free_count  out  P+1  number of free physical registers

Behaviour:
- Clock is clock; reset is asynchronous, active-high.
- On reset, both maps are identity (lreg i -> preg i).
- On reset, pregs 0..NUM_LREGS-1 are allocated and the rest free, in both free vectors.
- Reset values: free_count=NUM_PREGS-NUM_LREGS, req_ready=1.
- Reset mid-operation discards all state immediately.
- Outputs prs1/prs2/pdst/old_pdst are combinational from current state plus this cycle's inputs (0-cycle latency). All state updates at posedge.
- Effective destination dst_k = req_valid[k] & req_ldst_en[k] & (ldst_k != 0).
  - Lreg 0 is never renamed; its source lookup always returns preg 0.
  - pdst/old_pdst = 0 when dst_k=0.
- req_ready = !flush & (free_count >= W), independent of how many slots need a destination.
- fire = req_ready & |req_valid. A group is all-or-nothing; req_valid lanes need not be contiguous.
- Allocation: the j-th slot (ascending k) with dst_k takes the j-th lowest-indexed free preg in the speculative free vector.
- Intra-group bypass:
  - Slot k's prs1/prs2/old_pdst use the pdst of the highest-indexed slot i<k with dst_i and ldst_i equal to the looked-up lreg.
  - Otherwise they read the speculative map.
- On fire, for each dst_k:
  - Speculative map[ldst_k] <= pdst_k; if several slots match, the youngest wins.
  - Clear the spec free bit for pdst_k.
- Commit, for each commit_valid[k] & commit_ldst_en[k] & commit_ldst!=0:
  - Committed map[commit_ldst] <= commit_pdst; youngest slot wins.
  - Committed free vector: clear commit_pdst, set commit_old_pdst.
  - Spec free vector: set commit_old_pdst.
- A register freed by commit is not allocatable until the next cycle.
- Flush priority:
  - Spec map <= committed map including this cycle's commits.
  - Spec free vector <= committed free vector including this cycle's commits.
  - No rename fires on a flush cycle.
- free_count = popcount of the spec free vector (registered or recomputed, observed value after each edge).
- Freeing an already-free preg is a protocol violation; no checking is required (simulation assertion only).

Test Plan:
1. Reset, W=2, L=5, P=6 -> free_count=32, req_ready=1, prs1 for lrs1=7 is 7.
2. Slot0 ldst=3; slot1 lrs1=3, ldst=3 -> slot0 pdst=32, old_pdst=3; slot1 prs1=32, pdst=33, old_pdst=32. Next cycle lrs1=3 -> prs1=33, free_count=30.
3. Slot0 ldst=0 with req_ldst_en=1; slot1 ldst=5 -> slot0 pdst=0; slot1 pdst=32; free_count=31; prs of lreg 0 stays 0.
4. Issue 16 two-dest groups from reset -> free_count 0 after 16th, req_ready=0. Commit one slot with old_pdst=4 -> req_ready stays 0 (free_count=1 < W).
5. Rename ldst=3 -> 32, then assert flush with no commits -> next cycle lrs1=3 gives 3, free_count=32. Flush cycle with req_valid high -> no allocation.
6. Commit ldst=3/pdst=32/old=3 together with flush -> lrs1=3 gives 32, preg 3 free, free_count unchanged from committed vector. Reset asserted mid-group -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/rename_unit_if.sv
// Decode/commit/dispatch bundle for the rename stage.
// master = decode/commit side driving requests, slave = rename unit.
// Slot k of every packed lane vector sits at [k*width +: width].
interface rename_unit_if #(
  parameter int PLANE_WIDTH = 2,
  parameter int LREG_BITS   = 5,
  parameter int PREG_BITS   = 6
);
  localparam int W = PLANE_WIDTH;
  localparam int L = LREG_BITS;
  localparam int P = PREG_BITS;

  logic [W-1:0]   req_valid;
  logic [W-1:0]   req_ldst_en;
  logic [W*L-1:0] lrs1;
  logic [W*L-1:0] lrs2;
  logic [W*L-1:0] ldst;
  logic           req_ready;
  logic [W*P-1:0] prs1;
  logic [W*P-1:0] prs2;
  logic [W*P-1:0] pdst;
  logic [W*P-1:0] old_pdst;
  logic [W-1:0]   commit_valid;
  logic [W-1:0]   commit_ldst_en;
  logic [W*L-1:0] commit_ldst;
  logic [W*P-1:0] commit_pdst;
  logic [W*P-1:0] commit_old_pdst;
  logic           flush;
  logic [P:0]     free_count;

  modport master (
    output req_valid, req_ldst_en, lrs1, lrs2, ldst,
    output commit_valid, commit_ldst_en, commit_ldst, commit_pdst, commit_old_pdst, flush,
    input  req_ready, prs1, prs2, pdst, old_pdst, free_count
  );

  modport slave (
    input  req_valid, req_ldst_en, lrs1, lrs2, ldst,
    input  commit_valid, commit_ldst_en, commit_ldst, commit_pdst, commit_old_pdst, flush,
    output req_ready, prs1, prs2, pdst, old_pdst, free_count
  );
endinterface

// File: rtl/rename_unit.sv
// Register rename: W slots/cycle, bit-vector free list, speculative + committed maps.
// Latency: lookups/allocations are combinational (0 cycles); state updates at posedge.
// Backpressure: req_ready drops on flush or when fewer than W pregs are free; groups are all-or-nothing.
module rename_unit #(
  parameter int PLANE_WIDTH = 2,
  parameter int LREG_BITS   = 5,
  parameter int PREG_BITS   = 6
) (
  input  logic        clock,
  input  logic        reset,
  rename_unit_if.slave rif
);
  localparam int W         = PLANE_WIDTH;
  localparam int L         = LREG_BITS;
  localparam int P         = PREG_BITS;
  localparam int NUM_LREGS = 1 << L;
  localparam int NUM_PREGS = 1 << P;
  localparam logic [P:0] W_CNT = (P+1)'(W);
  localparam logic [NUM_PREGS-1:0] RESET_FREE =
    {{(NUM_PREGS-NUM_LREGS){1'b1}}, {NUM_LREGS{1'b0}}};

  logic [P-1:0]         spec_map   [NUM_LREGS];
  logic [P-1:0]         comm_map   [NUM_LREGS];
  logic [P-1:0]         comm_map_n [NUM_LREGS];
  logic [NUM_PREGS-1:0] spec_free, spec_free_n;
  logic [NUM_PREGS-1:0] comm_free, comm_free_n;

  logic [W-1:0] dst;
  logic [P-1:0] pdst_w  [W];
  logic [P-1:0] prs1_w  [W];
  logic [P-1:0] prs2_w  [W];
  logic [P-1:0] old_w   [W];
  logic [P:0]   free_cnt;
  logic         fire;
  logic [NUM_PREGS-1:0] avail;
  logic         found;

  // Effective destinations and in-order allocation of the lowest free pregs.
  always_comb begin
    avail = spec_free;
    found = 1'b0;
    for (int k = 0; k < W; k++) begin
      dst[k]    = rif.req_valid[k] & rif.req_ldst_en[k] & (rif.ldst[k*L +: L] != '0);
      pdst_w[k] = '0;
      found     = 1'b0;
      if (dst[k]) begin
        for (int i = 0; i < NUM_PREGS; i++) begin
          if (!found && avail[i]) begin
            pdst_w[k] = P'(i);
            found     = 1'b1;
          end
        end
        if (found) avail[pdst_w[k]] = 1'b0;
      end
    end
  end

  // Source/old-destination lookup with bypass from older slots in the same group.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      prs1_w[k] = (rif.lrs1[k*L +: L] == '0) ? '0 : spec_map[rif.lrs1[k*L +: L]];
      prs2_w[k] = (rif.lrs2[k*L +: L] == '0) ? '0 : spec_map[rif.lrs2[k*L +: L]];
      old_w[k]  = dst[k] ? spec_map[rif.ldst[k*L +: L]] : '0;
      for (int i = 0; i < W; i++) begin
        if (i < k && dst[i]) begin
          if (rif.ldst[i*L +: L] == rif.lrs1[k*L +: L]) prs1_w[k] = pdst_w[i];
          if (rif.ldst[i*L +: L] == rif.lrs2[k*L +: L]) prs2_w[k] = pdst_w[i];
          if (dst[k] && rif.ldst[i*L +: L] == rif.ldst[k*L +: L]) old_w[k] = pdst_w[i];
        end
      end
    end
  end

  // Pack per-slot results onto the interface lanes.
  always_comb begin
    rif.prs1     = '0;
    rif.prs2     = '0;
    rif.pdst     = '0;
    rif.old_pdst = '0;
    for (int k = 0; k < W; k++) begin
      rif.prs1[k*P +: P]     = prs1_w[k];
      rif.prs2[k*P +: P]     = prs2_w[k];
      rif.pdst[k*P +: P]     = pdst_w[k];
      rif.old_pdst[k*P +: P] = old_w[k];
    end
  end

  // Free count tracks the speculative free vector; ready needs a full group's worth.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) free_cnt = free_cnt + (P+1)'(spec_free[i]);
    rif.free_count = free_cnt;
    rif.req_ready  = !rif.flush && (free_cnt >= W_CNT);
    fire           = rif.req_ready && (|rif.req_valid);
  end

  // Next committed state and next speculative free vector (commits then allocations).
  always_comb begin
    comm_map_n  = comm_map;
    comm_free_n = comm_free;
    spec_free_n = spec_free;
    for (int k = 0; k < W; k++) begin
      if (rif.commit_valid[k] && rif.commit_ldst_en[k] && rif.commit_ldst[k*L +: L] != '0) begin
        comm_map_n[rif.commit_ldst[k*L +: L]]   = rif.commit_pdst[k*P +: P];
        comm_free_n[rif.commit_pdst[k*P +: P]]  = 1'b0;
        comm_free_n[rif.commit_old_pdst[k*P +: P]] = 1'b1;
        spec_free_n[rif.commit_old_pdst[k*P +: P]] = 1'b1;
      end
    end
    if (fire) begin
      for (int k = 0; k < W; k++) begin
        if (dst[k]) spec_free_n[pdst_w[k]] = 1'b0;
      end
    end
  end

  // State registers; flush rebuilds speculative state from the post-commit committed state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LREGS; i++) begin
        spec_map[i] <= P'(i);
        comm_map[i] <= P'(i);
      end
      spec_free <= RESET_FREE;
      comm_free <= RESET_FREE;
    end else begin
      comm_map  <= comm_map_n;
      comm_free <= comm_free_n;
      if (rif.flush) begin
        spec_map  <= comm_map_n;
        spec_free <= comm_free_n;
      end else begin
        spec_free <= spec_free_n;
        if (fire) begin
          for (int k = 0; k < W; k++) begin
            if (dst[k]) spec_map[rif.ldst[k*L +: L]] <= pdst_w[k];
          end
        end
      end
    end
  end

  // A committed old_pdst must still be allocated in the committed free vector.
  for (genvar g = 0; g < W; g++) begin : g_free_chk
    a_no_double_free: assert property (@(posedge clock) disable iff (reset)
      (rif.commit_valid[g] && rif.commit_ldst_en[g] && rif.commit_ldst[g*L +: L] != '0)
      |-> !comm_free[rif.commit_old_pdst[g*P +: P]]);
  end
endmodule
